// File: rtl/digital_clock_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : digital_clock_pkg
//  Brief    : Shared button FSM encoding and front-panel button indices.
//  Revision : 1.0
// ============================================================================
package digital_clock_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        ARM_PRESS   = 2'd1,
        HELD        = 2'd2,
        ARM_RELEASE = 2'd3
    } btn_state_t;

    localparam int BTN_MODE = 0;
    localparam int BTN_SET  = 1;
    localparam int BTN_OP1  = 2;
    localparam int BTN_OP2  = 3;

endpackage : digital_clock_pkg
`default_nettype wire

// File: rtl/button_debounce_channel.sv
`default_nettype none
// ============================================================================
//  Module   : button_debounce_channel
//  Brief    : One button: 2-flop synchronizer, stable-count debouncer, press/
//             release pulses; optional auto-repeat (BUTTON_AUTOREPEAT_EN).
//  Revision : 1.0
// ============================================================================
module button_debounce_channel
    import digital_clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
`ifdef BUTTON_AUTOREPEAT_EN
    ,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000,
    parameter bit REPEAT_EN       = 1'b0
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press,
    output logic rel
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    btn_state_t        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        r_sync;
    logic              w_s;
    logic              w_rpt_fire;

    assign w_s = r_sync[1];

`ifdef BUTTON_AUTOREPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_DELAY + 1);
    localparam logic [RPT_W-1:0] RPT_LAST   = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DELAY - REPEAT_RATE);

    generate
        if (REPEAT_EN) begin : g_repeat
            logic [RPT_W-1:0] r_rpt;

            // Zero on HELD entry, frozen in ARM_RELEASE, reloaded so later pulses come every REPEAT_RATE.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    r_rpt <= '0;
                end else if (r_state == IDLE || r_state == ARM_PRESS) begin
                    r_rpt <= '0;
                end else if (r_state == HELD && w_s) begin
                    r_rpt <= (r_rpt == RPT_LAST) ? RPT_RELOAD : r_rpt + 1'b1;
                end
            end

            assign w_rpt_fire = (r_state == HELD) && w_s && (r_rpt == RPT_LAST);
        end else begin : g_no_repeat
            assign w_rpt_fire = 1'b0;
        end
    endgenerate
`else
    assign w_rpt_fire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync  <= 2'b00;
            r_state <= IDLE;
            r_cnt   <= '0;
            level   <= 1'b0;
            press   <= 1'b0;
            rel     <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], raw};
            press  <= 1'b0;
            rel    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_s) begin
                        r_state <= ARM_PRESS;
                        r_cnt   <= '0;
                    end
                end
                ARM_PRESS: begin
                    if (!w_s) begin
                        r_state <= IDLE;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= HELD;
                        press   <= 1'b1;
                        level   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (!w_s) begin
                        r_state <= ARM_RELEASE;
                        r_cnt   <= '0;
                    end else if (w_rpt_fire) begin
                        press <= 1'b1;
                    end
                end
                ARM_RELEASE: begin
                    if (w_s) begin
                        r_state <= HELD;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= IDLE;
                        rel     <= 1'b1;
                        level   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule : button_debounce_channel
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : button_conditioner
//  Brief    : Conditions raw front-panel buttons into level/press/release
//             signals; auto-repeat enabled by BUTTON_AUTOREPEAT_EN.
//  Revision : 1.0
// ============================================================================
module button_conditioner
    import digital_clock_pkg::*;
#(
    parameter int                     NUM_BUTTONS     = 4,
    parameter int                     DEBOUNCE_CYCLES = 500000,
    parameter int                     REPEAT_DELAY    = 25000000,
    parameter int                     REPEAT_RATE     = 5000000,
    parameter logic [NUM_BUTTONS-1:0] REPEAT_MASK     = 4'b1100
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_BUTTONS-1:0] btn_raw,
    output logic [NUM_BUTTONS-1:0] btn_level,
    output logic [NUM_BUTTONS-1:0] btn_press,
    output logic [NUM_BUTTONS-1:0] btn_release
);

    generate
        for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_channel
            button_debounce_channel #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef BUTTON_AUTOREPEAT_EN
                ,
                .REPEAT_DELAY    (REPEAT_DELAY),
                .REPEAT_RATE     (REPEAT_RATE),
                .REPEAT_EN       (REPEAT_MASK[i])
`endif
            ) u_channel (
                .clk   (clk),
                .reset (reset),
                .raw   (btn_raw[i]),
                .level (btn_level[i]),
                .press (btn_press[i]),
                .rel   (btn_release[i])
            );
        end
    endgenerate

endmodule : button_conditioner
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_button_conditioner
//  Brief    : Directed stimulus with a pulse scoreboard for button_conditioner.
//  Revision : 1.0
// ============================================================================
module tb_button_conditioner;

    typedef struct {
        int         cyc;
        logic [3:0] press;
        logic [3:0] rel;
        logic [3:0] level;
    } ev_t;

    logic       clk;
    logic       reset;
    logic [3:0] btn_raw;
    logic [3:0] btn_level;
    logic [3:0] btn_press;
    logic [3:0] btn_release;

    int   cyc     = 0;
    int   checks  = 0;
    int   errors  = 0;
    logic rst_seen = 1'b0;
    ev_t  q[$];

    button_conditioner #(
        .NUM_BUTTONS     (4),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_RATE     (3),
        .REPEAT_MASK     (4'b1100)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= reset;
    end

    task automatic push(input int c, input logic [3:0] p, input logic [3:0] r, input logic [3:0] l);
        ev_t e;
        e.cyc = c; e.press = p; e.rel = r; e.level = l;
        q.push_back(e);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_level(input string name, input logic [3:0] exp);
        checks++;
        if (btn_level !== exp) begin
            errors++;
            $display("FAIL %s: btn_level=%b expected %b (cyc %0d)", name, btn_level, exp, cyc);
        end
    endtask

    // Monitor: outputs are sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst_seen) begin
            checks++;
            if (btn_level !== 4'b0 || btn_press !== 4'b0 || btn_release !== 4'b0) begin
                errors++;
                $display("FAIL reset_outputs: level=%b press=%b release=%b expected all 0 (cyc %0d)",
                         btn_level, btn_press, btn_release, cyc);
            end
        end else if ((|btn_press) || (|btn_release)) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: press=%b release=%b expected none (cyc %0d)",
                         btn_press, btn_release, cyc);
            end else begin
                ev_t e;
                e = q.pop_front();
                if (e.cyc != cyc || e.press !== btn_press || e.rel !== btn_release || e.level !== btn_level) begin
                    errors++;
                    $display("FAIL pulse_event: cyc=%0d press=%b release=%b level=%b expected cyc=%0d press=%b release=%b level=%b",
                             cyc, btn_press, btn_release, btn_level, e.cyc, e.press, e.rel, e.level);
                end
            end
        end else if (q.size() > 0 && q[0].cyc < cyc) begin
            ev_t e;
            e = q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_pulse: no pulse seen, expected press=%b release=%b at cyc %0d",
                     e.press, e.rel, e.cyc);
        end
    end

    initial begin
        int b;
        int c;
        reset   = 1'b0;
        btn_raw = 4'b1111;

        // Buttons held through reset are debounced afresh once reset lifts.
        wait_cycles(3);
        reset = 1'b1;
        push(cyc + 7, 4'b1111, 4'b0000, 4'b1111);
        wait_cycles(10);
        btn_raw = 4'b0000;
        push(cyc + 7, 4'b0000, 4'b1111, 4'b0000);
        wait_cycles(10);

        // Clean press and release on mode.
        btn_raw[0] = 1'b1;
        push(cyc + 7, 4'b0001, 4'b0000, 4'b0001);
        wait_cycles(10);
        check_level("mode_held_level", 4'b0001);
        wait_cycles(10);
        btn_raw[0] = 1'b0;
        push(cyc + 7, 4'b0000, 4'b0001, 4'b0000);
        wait_cycles(10);

        // Bouncing set button must be rejected.
        for (int i = 0; i < 6; i++) begin
            btn_raw[1] = ~btn_raw[1];
            wait_cycles(1);
        end
        btn_raw[1] = 1'b0;
        wait_cycles(10);
        check_level("bounce_level", 4'b0000);

        // Simultaneous op1/op2 press, short glitch on op2 while held.
        btn_raw = 4'b1100;
        b = cyc;
        push(b + 7, 4'b1100, 4'b0000, 4'b1100);
        wait_cycles(10);
        btn_raw[3] = 1'b0;
        wait_cycles(2);
        btn_raw[3] = 1'b1;
        wait_cycles(2);
        check_level("glitch_level", 4'b1100);
        wait_cycles(1);
        btn_raw = 4'b0000;
        push(b + 22, 4'b0000, 4'b1100, 4'b0000);
        wait_cycles(10);

        // Long hold on op1 (repeat-capable) together with mode (never repeats).
        btn_raw = 4'b0101;
        c = cyc;
        push(c + 7, 4'b0101, 4'b0000, 4'b0101);
`ifdef BUTTON_AUTOREPEAT_EN
        for (int k = 17; k <= 38; k += 3) push(c + k, 4'b0100, 4'b0000, 4'b0101);
`endif
        wait_cycles(38);
        btn_raw = 4'b0000;
        push(c + 45, 4'b0000, 4'b0101, 4'b0000);
        wait_cycles(10);

        // Reset while set is part-way through its press debounce.
        btn_raw[1] = 1'b1;
        wait_cycles(5);
        reset = 1'b0;
        wait_cycles(2);
        reset = 1'b1;
        push(cyc + 7, 4'b0010, 4'b0000, 4'b0010);
        wait_cycles(10);
        btn_raw[1] = 1'b0;
        push(cyc + 7, 4'b0000, 4'b0010, 4'b0000);
        wait_cycles(12);

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL pending_events: %0d expected pulses never seen, required 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_button_conditioner
`default_nettype wire
